// File: rtl/brc_iter.sv
// Multi-cycle branch comparator: compares rs1 against rs2 one CHUNK at a time, most-significant
// chunk first, and returns registered less-than (signed/unsigned) and equal flags.
module brc_iter #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_br_un,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_less,
  output logic             o_br_equal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

  // Handshakes: a request is accepted on a rising edge where i_valid=1 and o_ready=1 (IDLE only,
  // and not while i_flush=1). A result is consumed on a rising edge where o_valid=1 and i_ready=1.
  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_un;
  logic [IW-1:0]     r_idx;
  logic              r_found;
  logic              r_found_lt;
  logic              r_less;
  logic              r_equal;

  logic [CHUNK-1:0]  w_a_chunk [NCHUNK];
  logic [CHUNK-1:0]  w_b_chunk [NCHUNK];
  logic [CHUNK-1:0]  w_flip;
  logic [CHUNK-1:0]  w_ca;
  logic [CHUNK-1:0]  w_cb;
  logic              w_diff;
  logic              w_lt;
  logic              w_accept;
  logic              w_finish;
  logic              w_res_less;
  logic              w_res_equal;

  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    assign w_a_chunk[g] = r_a[g*CHUNK +: CHUNK];
    assign w_b_chunk[g] = r_b[g*CHUNK +: CHUNK];
  end

  // Flipping the sign bit of the top chunk turns a signed compare into an unsigned one.
  assign w_flip = ((r_idx == IW'(NCHUNK - 1)) && !r_un) ? MSB_MASK : '0;
  assign w_ca   = w_a_chunk[r_idx] ^ w_flip;
  assign w_cb   = w_b_chunk[r_idx] ^ w_flip;
  assign w_diff = (w_ca != w_cb);
  assign w_lt   = (w_ca < w_cb);

  always_comb begin
    w_res_less  = 1'b0;
    w_res_equal = 1'b0;
    if (r_found) begin
      w_res_less = r_found_lt;
    end else if (w_diff) begin
      w_res_less = w_lt;
    end else begin
      w_res_equal = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_flush && i_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
        end else if (((EARLY_EXIT != 0) && w_diff) || (r_idx == '0)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_flush || i_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_un       <= 1'b0;
      r_idx      <= '0;
      r_found    <= 1'b0;
      r_found_lt <= 1'b0;
      r_less     <= 1'b0;
      r_equal    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= i_rs1_data;
        r_b     <= i_rs2_data;
        r_un    <= i_br_un;
        r_idx   <= IW'(NCHUNK - 1);
        r_found <= 1'b0;
      end
      if (r_state == S_CMP && !i_flush) begin
        // Only the first (most significant) difference is kept when scanning all chunks.
        if (w_diff && !r_found) begin
          r_found    <= 1'b1;
          r_found_lt <= w_lt;
        end
        if (!w_finish) r_idx <= r_idx - IW'(1);
      end
      if (w_finish) begin
        r_less  <= w_res_less;
        r_equal <= w_res_equal;
      end
    end
  end

  assign o_ready    = (r_state == S_IDLE);
  assign o_valid    = (r_state == S_DONE);
  assign o_br_less  = r_less;
  assign o_br_equal = r_equal;

endmodule

// File: tb/tb_brc_iter.sv
// Bench for brc_iter: an early-exit and a full-scan instance share stimulus; results are
// checked against a scoreboard queue fed from a vector table, random vectors and corner sequences.
module tb_brc_iter;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        br_un;
  logic        flush;
  logic        i_ready;
  logic        ready_e, valid_e, less_e, equal_e;
  logic        ready_f, valid_f, less_f, equal_f;

  int n_checks = 0;
  int n_fail   = 0;

  // exp record: {less, equal, done cycle early-exit[7:0], done cycle full-scan[7:0]}
  logic [17:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        un;
    logic        less;
    logic        equal;
    int          cyc_e;
    int          cyc_f;
  } vec_t;

  brc_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ready_e),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un), .i_flush(flush),
    .o_valid(valid_e), .i_ready(i_ready), .o_br_less(less_e), .o_br_equal(equal_e)
  );

  brc_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ready_f),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un), .i_flush(flush),
    .o_valid(valid_f), .i_ready(i_ready), .o_br_less(less_f), .o_br_equal(equal_f)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole-word compare, chunk count from the first differing byte.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic un);
    vec_t v;
    int   k;
    v.a = a; v.b = b; v.un = un;
    v.equal = (a == b);
    v.less  = un ? (a < b) : ($signed(a) < $signed(b));
    k = 4;
    for (int i = 3; i >= 0; i--) begin
      if (a[i*8 +: 8] != b[i*8 +: 8]) begin
        k = 4 - i;
        break;
      end
    end
    v.cyc_e = k + 1;
    v.cyc_f = 5;
    return v;
  endfunction

  // Driver: accept one request, wait for both results, compare against the scoreboard, release.
  task automatic run_req(input vec_t v);
    int          cyc;
    bit          got_e, got_f;
    int          c_e, c_f;
    logic        l_e, q_e, l_f, q_f;
    logic [17:0] exp;
    exp_q.push_back({v.less, v.equal, 8'(v.cyc_e), 8'(v.cyc_f)});
    @(negedge clk);
    check("ready_e_before", 32'(ready_e), 32'd1);
    check("ready_f_before", 32'(ready_f), 32'd1);
    i_valid = 1'b1; rs1 = v.a; rs2 = v.b; br_un = v.un;
    @(posedge clk); #1;
    i_valid = 1'b0;
    cyc = 1; got_e = 0; got_f = 0; c_e = 0; c_f = 0;
    l_e = 0; q_e = 0; l_f = 0; q_f = 0;
    while (!(got_e && got_f) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (!got_e && valid_e) begin got_e = 1; c_e = cyc; l_e = less_e; q_e = equal_e; end
      if (!got_f && valid_f) begin got_f = 1; c_f = cyc; l_f = less_f; q_f = equal_f; end
    end
    exp = exp_q.pop_front();
    if (!(got_e && got_f)) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: got valid_e=%0d valid_f=%0d expected both within 50 cycles", got_e, got_f);
    end
    check("less_e",  32'(l_e), 32'(exp[17]));
    check("equal_e", 32'(q_e), 32'(exp[16]));
    check("cycle_e", 32'(c_e), 32'(exp[15:8]));
    check("less_f",  32'(l_f), 32'(exp[17]));
    check("equal_f", 32'(q_f), 32'(exp[16]));
    check("cycle_f", 32'(c_f), 32'(exp[7:0]));
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("ready_e_after", 32'(ready_e), 32'd1);
    check("valid_e_after", 32'(valid_e), 32'd0);
    check("ready_f_after", 32'(ready_f), 32'd1);
  endtask

  initial begin
    vec_t tbl[12];
    vec_t v;
    logic [31:0] a, b;

    tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 2, 5};
    tbl[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 2, 5};
    tbl[2]  = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 2, 5};
    tbl[3]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 2, 5};
    tbl[4]  = '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 5, 5};
    tbl[5]  = '{32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b1, 5, 5};
    tbl[6]  = '{32'h00000001, 32'h00000002, 1'b1, 1'b1, 1'b0, 5, 5};
    tbl[7]  = '{32'h12345600, 32'h12345700, 1'b0, 1'b1, 1'b0, 4, 5};
    tbl[8]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2, 5};
    tbl[9]  = '{32'h00FF0000, 32'h00FE0000, 1'b1, 1'b0, 1'b0, 3, 5};
    tbl[10] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 5, 5};
    tbl[11] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5, 5};

    rst_n = 1'b0; i_valid = 1'b0; rs1 = '0; rs2 = '0; br_un = 1'b0; flush = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_e), 32'd0);
    check("rst_less",  32'(less_e), 32'd0);
    check("rst_equal", 32'(equal_e), 32'd0);
    check("rst_ready", 32'(ready_e), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_req(tbl[i]);

    // Random operands, upper bytes often shared so every exit chunk gets exercised.
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        1: b[31:24] = a[31:24];
        2: b[31:16] = a[31:16];
        3: b[31:8]  = a[31:8];
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) b = a;
      v = model(a, b, 1'($urandom_range(0, 1)));
      run_req(v);
    end

    // Backpressure: result held while new operands are offered.
    @(negedge clk);
    i_valid = 1'b1; rs1 = 32'hFFFFFFFF; rs2 = 32'h00000001; br_un = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_valid_e_start", 32'(valid_e), 32'd1);
    check("bp_valid_f_start", 32'(valid_f), 32'd1);
    @(negedge clk);
    i_valid = 1'b1; rs1 = 32'h0; rs2 = 32'h0; br_un = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_valid_e", 32'(valid_e), 32'd1);
      check("bp_less_e",  32'(less_e), 32'd1);
      check("bp_equal_e", 32'(equal_e), 32'd0);
      check("bp_ready_e", 32'(ready_e), 32'd0);
      check("bp_valid_f", 32'(valid_f), 32'd1);
      check("bp_less_f",  32'(less_f), 32'd1);
    end
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("bp_ready_e_after", 32'(ready_e), 32'd1);
    check("bp_ready_f_after", 32'(ready_f), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_no_accept_e", 32'(valid_e), 32'd0);
    check("bp_no_accept_f", 32'(ready_f), 32'd1);

    // Flush during CMP: no result, flags keep the previous values.
    @(negedge clk);
    i_valid = 1'b1; rs1 = 32'h12345678; rs2 = 32'h12345678; br_un = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_ready_e", 32'(ready_e), 32'd1);
    check("fl_ready_f", 32'(ready_f), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("fl_valid_e", 32'(valid_e), 32'd0);
      check("fl_valid_f", 32'(valid_f), 32'd0);
    end
    check("fl_less_e",  32'(less_e), 32'd1);
    check("fl_equal_e", 32'(equal_e), 32'd0);

    // Flush beats accept in IDLE.
    @(negedge clk);
    i_valid = 1'b1; flush = 1'b1; rs1 = 32'h1; rs2 = 32'h2; br_un = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; flush = 1'b0;
    check("fl_idle_ready_e", 32'(ready_e), 32'd1);
    check("fl_idle_ready_f", 32'(ready_f), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("fl_idle_valid_e", 32'(valid_e), 32'd0);

    // Async reset in the middle of CMP.
    @(negedge clk);
    i_valid = 1'b1; rs1 = 32'h12345678; rs2 = 32'h12345678; br_un = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_f", 32'(valid_f), 32'd0);
    check("mid_rst_less_e",  32'(less_e), 32'd0);
    check("mid_rst_less_f",  32'(less_f), 32'd0);
    check("mid_rst_equal_f", 32'(equal_f), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready_e", 32'(ready_e), 32'd1);
    check("mid_rst_ready_f", 32'(ready_f), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_valid", 32'(valid_f), 32'd0);

    // Normal operation resumes after reset.
    run_req(tbl[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
